// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared state encoding and width helper for the matrix multiplier
package matmul_pkg;

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        COMPUTE = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    // Product is 2*dw bits; summing n of them needs clog2(n) guard bits.
    function automatic int acc_width(input int n, input int dw);
        return 2 * dw + $clog2(n);
    endfunction

endpackage

// File: rtl/matmul_mac.sv
// rtl/matmul_mac.sv - multiply plus registered accumulator; MATMUL_SIGNED_EN selects signed operands
module matmul_mac #(
    parameter int DW   = 8,
    parameter int ACCW = 18
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_en,
    input  logic            i_first,
    input  logic [DW-1:0]   i_a,
    input  logic [DW-1:0]   i_b,
    output logic [ACCW-1:0] o_acc
);

    logic [ACCW-1:0] r_acc;
    logic [ACCW-1:0] w_prod_ext;
    logic [ACCW-1:0] w_base;
    logic [ACCW-1:0] w_sum;

`ifdef MATMUL_SIGNED_EN
    logic signed [2*DW-1:0] w_prod;
    assign w_prod     = $signed({{DW{i_a[DW-1]}}, i_a}) * $signed({{DW{i_b[DW-1]}}, i_b});
    assign w_prod_ext = {{(ACCW-2*DW){w_prod[2*DW-1]}}, w_prod};
`else
    logic [2*DW-1:0] w_prod;
    assign w_prod     = {{DW{1'b0}}, i_a} * {{DW{1'b0}}, i_b};
    assign w_prod_ext = {{(ACCW-2*DW){1'b0}}, w_prod};
`endif

    // First term of a dot product starts from zero instead of the stale sum.
    assign w_base = i_first ? '0 : r_acc;
    assign w_sum  = w_base + w_prod_ext;
    assign o_acc  = r_acc;

    // Accumulator register, advances only on enabled MAC cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= w_sum;
        end
    end

endmodule

// File: rtl/matrix_mult_seq.sv
// rtl/matrix_mult_seq.sv - sequential NxN matrix multiplier top; MATMUL_SIGNED_EN selects signed arithmetic
module matrix_mult_seq
    import matmul_pkg::*;
#(
    parameter int N  = 4,
    parameter int DW = 8,
    localparam int ACCW = acc_width(N, DW)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ACCW-1:0] out_data,
    output logic            busy,
    output logic            done
);

    localparam int NN = N * N;
    localparam int IW = $clog2(NN);
    localparam int KW = $clog2(N);
    localparam logic [IW-1:0] IDX_LAST = IW'(NN - 1);
    localparam logic [IW-1:0] N_IW     = IW'(N);
    localparam logic [KW-1:0] K_LAST   = KW'(N - 1);

    state_t          r_state;
    state_t          w_next;
    logic [IW-1:0]   r_ld_idx;
    logic [IW-1:0]   r_out_idx;
    logic [IW-1:0]   r_wb_idx;
    logic [KW-1:0]   r_i;
    logic [KW-1:0]   r_j;
    logic [KW-1:0]   r_k;
    logic            r_mac_end;
    logic            r_wb_valid;
    logic            r_done;

    logic [DW-1:0]   r_a [NN];
    logic [DW-1:0]   r_b [NN];
    logic [ACCW-1:0] r_c [NN];

    logic            w_in_fire;
    logic            w_out_fire;
    logic            w_ld_last;
    logic            w_out_last;
    logic            w_mac_en;
    logic            w_mac_last;
    logic [IW-1:0]   w_i_ext;
    logic [IW-1:0]   w_j_ext;
    logic [IW-1:0]   w_k_ext;
    logic [IW-1:0]   w_a_idx;
    logic [IW-1:0]   w_b_idx;
    logic [ACCW-1:0] w_acc;

    // Handshake qualifiers use state directly so in_ready/out_valid never feed back.
    assign w_in_fire  = in_valid && (r_state == LOAD_A || r_state == LOAD_B);
    assign w_out_fire = out_ready && (r_state == DRAIN);
    assign w_ld_last  = (r_ld_idx == IDX_LAST);
    assign w_out_last = (r_out_idx == IDX_LAST);

    // MAC runs for N^3 cycles; r_mac_end marks the final flush cycle that lets the
    // last accumulated element land in the C bank before DRAIN reads it.
    assign w_mac_en   = (r_state == COMPUTE) && !r_mac_end;
    assign w_mac_last = w_mac_en && (r_i == K_LAST) && (r_j == K_LAST) && (r_k == K_LAST);

    assign w_i_ext = IW'(r_i);
    assign w_j_ext = IW'(r_j);
    assign w_k_ext = IW'(r_k);
    assign w_a_idx = w_i_ext * N_IW + w_k_ext;
    assign w_b_idx = w_k_ext * N_IW + w_j_ext;

    assign out_data = (r_state == DRAIN) ? r_c[r_out_idx] : '0;
    assign done     = r_done;

    matmul_mac #(
        .DW   (DW),
        .ACCW (ACCW)
    ) u_mac (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_mac_en),
        .i_first (r_k == '0),
        .i_a     (r_a[w_a_idx]),
        .i_b     (r_b[w_b_idx]),
        .o_acc   (w_acc)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= LOAD_A;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and state-decoded handshake outputs.
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (r_state)
            LOAD_A: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid && w_ld_last) w_next = LOAD_B;
            end
            LOAD_B: begin
                in_ready = 1'b1;
                if (in_valid && w_ld_last) w_next = COMPUTE;
            end
            COMPUTE: begin
                if (r_mac_end) w_next = DRAIN;
            end
            DRAIN: begin
                out_valid = 1'b1;
                if (out_ready && w_out_last) w_next = LOAD_A;
            end
            default: w_next = LOAD_A;
        endcase
    end

    // Load write index, shared by A and B, wraps when each bank fills.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ld_idx <= '0;
        end else if (w_in_fire) begin
            r_ld_idx <= w_ld_last ? '0 : r_ld_idx + 1'b1;
        end
    end

    // Operand and result banks; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (w_in_fire && r_state == LOAD_A) r_a[r_ld_idx] <= in_data;
        if (w_in_fire && r_state == LOAD_B) r_b[r_ld_idx] <= in_data;
        if (r_wb_valid) r_c[r_wb_idx] <= w_acc;
    end

    // i/j/k loop counters with k innermost, plus delayed write-back of each finished dot product.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_i        <= '0;
            r_j        <= '0;
            r_k        <= '0;
            r_mac_end  <= 1'b0;
            r_wb_valid <= 1'b0;
            r_wb_idx   <= '0;
        end else begin
            r_wb_valid <= w_mac_en && (r_k == K_LAST);
            r_wb_idx   <= w_i_ext * N_IW + w_j_ext;
            if (w_mac_en) begin
                r_k <= (r_k == K_LAST) ? '0 : r_k + 1'b1;
                if (r_k == K_LAST) begin
                    r_j <= (r_j == K_LAST) ? '0 : r_j + 1'b1;
                    if (r_j == K_LAST) begin
                        r_i <= (r_i == K_LAST) ? '0 : r_i + 1'b1;
                    end
                end
                if (w_mac_last) r_mac_end <= 1'b1;
            end else if (r_state == COMPUTE) begin
                r_mac_end <= 1'b0;
            end
        end
    end

    // Drain read index and the done pulse one cycle after the last C transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_idx <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_out_fire && w_out_last;
            if (w_out_fire) begin
                r_out_idx <= w_out_last ? '0 : r_out_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_matrix_mult_seq.sv
// tb/tb_matrix_mult_seq.sv - scoreboard bench for matrix_mult_seq (N=4/DW=8 and N=2/DW=4)
module tb_matrix_mult_seq;

    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int ACCW  = 2 * DW + 2;
    localparam int N2    = 2;
    localparam int DW2   = 4;
    localparam int ACCW2 = 2 * DW2 + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    in_data;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [ACCW-1:0]  out_data;
    logic             busy;
    logic             done;

    logic             rst2;
    logic             in2_valid;
    logic             in2_ready;
    logic [DW2-1:0]   in2_data;
    logic             out2_valid;
    logic             out2_ready = 1'b1;
    logic [ACCW2-1:0] out2_data;
    logic             busy2;
    logic             done2;

    matrix_mult_seq #(.N(N), .DW(DW)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done)
    );

    matrix_mult_seq #(.N(N2), .DW(DW2)) u_dut2 (
        .clk       (clk),
        .rst       (rst2),
        .in_valid  (in2_valid),
        .in_ready  (in2_ready),
        .in_data   (in2_data),
        .out_valid (out2_valid),
        .out_ready (out2_ready),
        .out_data  (out2_data),
        .busy      (busy2),
        .done      (done2)
    );

    int total = 0;
    int bad   = 0;
    int done_cnt  = 0;
    int done_cyc  = 0;
    int done2_cnt = 0;
    logic bp_en = 1'b0;

    logic [ACCW-1:0]  exp_q[$];
    logic [ACCW2-1:0] exp2_q[$];

    logic [DW-1:0] m_id   [16];
    logic [DW-1:0] m_pat  [16];
    logic [DW-1:0] m_row  [16];
    logic [DW-1:0] m_ones [16];
    logic [DW-1:0] m_big  [16];
    logic [DW-1:0] m_neg1 [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Backpressure generator on the result port.
    initial forever begin
        @(posedge clk);
        #1;
        out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Scoreboard monitor for the N=4 instance.
    always @(negedge clk) begin
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
                check("out_data", 32'(out_data), 32'(exp_q[0]));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            check("done_in_load_a", 32'(busy), 32'd0);
        end
    end

    // Scoreboard monitor for the N=2 instance.
    always @(negedge clk) begin
        if (out2_valid) begin
            if (exp2_q.size() == 0) begin
                check("unexpected_out2", 32'(out2_data), 32'hFFFF_FFFF);
            end else begin
                check("out2_data", 32'(out2_data), 32'(exp2_q[0]));
                if (out2_ready) void'(exp2_q.pop_front());
            end
        end
        if (done2) done2_cnt++;
    end

    task automatic send(input int which, input logic [7:0] d, input int gaps);
        int   n;
        logic acc;
        in_valid  = 1'b0;
        in2_valid = 1'b0;
        repeat (gaps) begin
            @(posedge clk);
            #1;
        end
        if (which == 0) begin
            in_valid = 1'b1;
            in_data  = d;
        end else begin
            in2_valid = 1'b1;
            in2_data  = d[3:0];
        end
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = (which == 0) ? in_ready : in2_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) check("send_timeout", 32'd0, 32'd1);
        in_valid  = 1'b0;
        in2_valid = 1'b0;
    endtask

    task automatic load_pair(input logic [DW-1:0] a [16], input logic [DW-1:0] b [16], input int maxgap);
        for (int x = 0; x < 16; x++) send(0, a[x], (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap)));
        for (int x = 0; x < 16; x++) send(0, b[x], (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap)));
    endtask

    task automatic push_const(input logic [ACCW-1:0] v);
        for (int x = 0; x < 16; x++) exp_q.push_back(v);
    endtask

    task automatic push_seq();
        for (int x = 0; x < 16; x++) exp_q.push_back(ACCW'(x));
    endtask

    task automatic wait_done(input int which);
        int   n;
        logic seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 3000) begin
            @(negedge clk);
            seen = (which == 0) ? done : done2;
            n++;
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  32'(in_ready),  32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_data"},  32'(out_data),  32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_done"},      32'(done),      32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        logic [7:0] a2 [4];
        logic [7:0] b2 [4];
        rst       = 1'b1;
        rst2      = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in2_valid = 1'b0;
        in2_data  = '0;
        a2 = '{8'd1, 8'd0, 8'd0, 8'd1};
        b2 = '{8'd0, 8'd1, 8'd2, 8'd3};
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                m_id[4*r+c]   = (r == c) ? 8'd1 : 8'd0;
                m_pat[4*r+c]  = 8'(4*r + c);
                m_row[4*r+c]  = 8'(r + 1);
                m_ones[4*r+c] = 8'd1;
                m_big[4*r+c]  = 8'hFF;
                m_neg1[4*r+c] = 8'hFF;
            end
        end

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        check("reset2_in_ready", 32'(in2_ready), 32'd1);
        check("reset2_out_valid", 32'(out2_valid), 32'd0);
        rst  = 1'b0;
        rst2 = 1'b0;
        @(posedge clk);
        #1;

        // Identity A: C equals B, row-major 0..15, 113 cycles, one done pulse.
        push_seq();
        done_cnt = 0;
        t0 = cyc + 1;
        load_pair(m_id, m_pat, 0);
        wait_done(0);
        check("throughput_cycles", 32'(done_cyc - t0 + 1), 32'd113);
        check("done_count", 32'(done_cnt), 32'd1);
        check("queue_empty_identity", 32'(exp_q.size()), 32'd0);

        // Identity B with random backpressure in DRAIN: C equals A.
        push_seq();
        bp_en = 1'b1;
        load_pair(m_pat, m_id, 0);
        wait_done(0);
        bp_en = 1'b0;
        check("queue_empty_backpressure", 32'(exp_q.size()), 32'd0);

`ifdef MATMUL_SIGNED_EN
        // -128 everywhere: 4 * 16384 = 65536.
        for (int x = 0; x < 16; x++) m_big[x] = 8'h80;
        push_const(18'd65536);
        load_pair(m_big, m_big, 0);
        wait_done(0);
        // Rows of -1 times columns of 1: -4.
        push_const(18'h3FFFC);
        load_pair(m_neg1, m_ones, 0);
        wait_done(0);
`else
        // 255 everywhere: 4 * 65025 = 260100 fits in 18 bits.
        push_const(18'd260100);
        load_pair(m_big, m_big, 0);
        wait_done(0);
        // All-ones A: 255 * 4 = 1020 per element.
        push_const(18'd1020);
        load_pair(m_neg1, m_ones, 0);
        wait_done(0);
`endif

        // Row-constant A times all-ones B with input gaps: rows 4, 8, 12, 16.
        for (int x = 0; x < 16; x++) exp_q.push_back(ACCW'(4 * (x / 4 + 1)));
        load_pair(m_row, m_ones, 3);
        in_valid = 1'b1;
        in_data  = 8'hAA;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (done) break;
            check("in_ready_while_busy", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("queue_empty_gaps", 32'(exp_q.size()), 32'd0);

        // A fresh load after held in_valid must be unaffected by the stray words.
        push_seq();
        load_pair(m_id, m_pat, 0);
        wait_done(0);

        // Reset in the 5th COMPUTE cycle, then a fresh identity load.
        done_cnt = 0;
        load_pair(m_id, m_pat, 0);
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_reset_outputs("midreset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_done", 32'(done_cnt), 32'd0);
        push_seq();
        load_pair(m_id, m_pat, 0);
        wait_done(0);
        check("done_after_reset", 32'(done_cnt), 32'd1);

        // Same scenario on the N=2, DW=4 instance.
        for (int x = 0; x < 4; x++) send(1, a2[x], 0);
        for (int x = 0; x < 4; x++) send(1, b2[x], 0);
        repeat (4) @(posedge clk);
        #3;
        rst2 = 1'b1;
        #1;
        check("midreset2_in_ready", 32'(in2_ready), 32'd1);
        check("midreset2_out_valid", 32'(out2_valid), 32'd0);
        check("midreset2_out_data", 32'(out2_data), 32'd0);
        check("midreset2_busy", 32'(busy2), 32'd0);
        @(posedge clk);
        #1;
        rst2 = 1'b0;
        for (int x = 0; x < 4; x++) exp2_q.push_back(ACCW2'(x));
        for (int x = 0; x < 4; x++) send(1, a2[x], 0);
        for (int x = 0; x < 4; x++) send(1, b2[x], 0);
        wait_done(1);
        check("done2_count", 32'(done2_cnt), 32'd1);
        check("queue2_empty", 32'(exp2_q.size()), 32'd0);
        check("queue_empty_final", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
